// File: rtl/codec_cfg_sequencer_pkg.sv
// codec_cfg_pkg: shared types and the codec configuration table.
//
// Contents
//   cfg_state_t    sequencer FSM state encoding
//   CFG_TABLE_LEN  number of meaningful entries in the built-in table
//   pack_entry()   builds a 16-bit table word {reg_addr[6:0], reg_val[8:0]}
//   cfg_word()     returns table entry idx; indices past the table give 16'h0000
//
// Used by codec_cfg_sequencer and codec_cfg_rom.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_START,
    ST_GUARD,
    ST_WAIT,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } cfg_state_t;

  localparam int unsigned CFG_TABLE_LEN = 10;
  localparam int unsigned CFG_IDX_W     = 4;

  function automatic logic [15:0] pack_entry(input logic [6:0] reg_addr,
                                             input logic [8:0] reg_val);
    return {reg_addr, reg_val};
  endfunction

  // Bring-up order matters: reset first, then power and format settings,
  // and the active bit last so the codec starts only once fully configured.
  function automatic logic [15:0] cfg_word(input logic [CFG_IDX_W-1:0] idx);
    logic [15:0] word;
    case (idx)
      4'd0:    word = pack_entry(7'h0F, 9'h000); // reset
      4'd1:    word = pack_entry(7'h06, 9'h010); // power down control
      4'd2:    word = pack_entry(7'h00, 9'h017); // left line in
      4'd3:    word = pack_entry(7'h01, 9'h017); // right line in
      4'd4:    word = pack_entry(7'h02, 9'h079); // left headphone
      4'd5:    word = pack_entry(7'h03, 9'h079); // right headphone
      4'd6:    word = pack_entry(7'h04, 9'h012); // analogue path
      4'd7:    word = pack_entry(7'h05, 9'h000); // digital path
      4'd8:    word = pack_entry(7'h07, 9'h00A); // interface format
      4'd9:    word = pack_entry(7'h09, 9'h001); // active
      default: word = 16'h0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// codec_cfg_sequencer_if: handshake between the config sequencer and the I2C
// write engine.
//
// Signals
//   i2c_start  1-cycle start pulse (sequencer -> engine)
//   i2c_data   24-bit transfer {dev_addr, reg_word}, stable from start until done
//   i2c_done   engine finished; held high until the next start
//   i2c_ack    1 = all bytes ACKed, valid while i2c_done is high
//
// Modports: master = sequencer side, slave = engine side.
interface codec_cfg_sequencer_if;

  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        i2c_done;
  logic        i2c_ack;

  modport master (
    output i2c_start,
    output i2c_data,
    input  i2c_done,
    input  i2c_ack
  );

  modport slave (
    input  i2c_start,
    input  i2c_data,
    output i2c_done,
    output i2c_ack
  );

endinterface

// File: rtl/codec_cfg_sequencer_rom.sv
// codec_cfg_rom: combinational lookup of the codec configuration table.
//
// Ports
//   idx   in   4   table index
//   word  out  16  table entry; 16'h0000 when idx >= NUM_REGS
module codec_cfg_rom
  import codec_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS = CFG_TABLE_LEN
) (
  input  logic [CFG_IDX_W-1:0] idx,
  output logic [15:0]          word
);

  always_comb begin
    word = 16'h0000;
    if (32'(idx) < NUM_REGS) begin
      word = cfg_word(idx);
    end
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: waits for codec power-up, then writes the configuration
// table to the codec through the I2C write engine, one 24-bit transfer per
// entry, and reports completion or the index of the first failing entry.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high
//   cfg_go     in   1   restart pulse, honoured only in DONE/ERR
//   i2c        master modport of codec_cfg_sequencer_if (start/data/done/ack)
//   busy       out  1   sequence in progress
//   cfg_done   out  1   all entries written and ACKed
//   cfg_err    out  1   sequence aborted on a NACK
//   err_index  out  4   index of the failing entry (valid while cfg_err)
//
// Build option
//   CFG_RETRY_EN  when defined, a NACKed entry is re-sent up to RETRY_MAX
//                 times before the sequence aborts; when undefined the first
//                 NACK aborts and no retry counter exists.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR     = 8'h34,
  parameter int unsigned NUM_REGS     = CFG_TABLE_LEN,
`ifdef CFG_RETRY_EN
  parameter int unsigned RETRY_MAX    = 3,
`endif
  parameter int unsigned PWRUP_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_go,
  codec_cfg_sequencer_if.master i2c,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [CFG_IDX_W-1:0]  err_index
);

  localparam int unsigned        PWR_W    = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [PWR_W-1:0]   PWR_LAST = PWR_W'(PWRUP_CYCLES - 1);
  localparam logic [CFG_IDX_W-1:0] IDX_LAST = CFG_IDX_W'(NUM_REGS - 1);

  cfg_state_t           state;
  logic [CFG_IDX_W-1:0] idx;
  logic [PWR_W-1:0]     pwr_cnt;
  logic [15:0]          rom_word;
  logic                 retry_ok;

  codec_cfg_rom #(
    .NUM_REGS(NUM_REGS)
  ) u_rom (
    .idx (idx),
    .word(rom_word)
  );

`ifdef CFG_RETRY_EN
  localparam int unsigned RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  logic [RETRY_W-1:0] retry_cnt;
  assign retry_ok = (32'(retry_cnt) < RETRY_MAX);
`else
  assign retry_ok = 1'b0;
`endif

  // All outputs are registered and change on the transition into the state
  // they describe, so e.g. i2c_start is high exactly while state == ST_START.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_PWRUP;
      idx           <= '0;
      pwr_cnt       <= '0;
      i2c.i2c_start <= 1'b0;
      i2c.i2c_data  <= 24'h000000;
      busy          <= 1'b1;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      err_index     <= '0;
`ifdef CFG_RETRY_EN
      retry_cnt     <= '0;
`endif
    end else begin
      i2c.i2c_start <= 1'b0;
      case (state)
        ST_PWRUP: begin
          if (pwr_cnt == PWR_LAST) begin
            state <= ST_LOAD;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          i2c.i2c_data  <= {DEV_ADDR, rom_word};
          i2c.i2c_start <= 1'b1;
          state         <= ST_START;
        end
        ST_START: state <= ST_GUARD;
        // The engine's done from the previous transfer may still be high
        // in the cycle right after start; skip it before watching done.
        ST_GUARD: state <= ST_WAIT;
        ST_WAIT: begin
          if (i2c.i2c_done) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (i2c.i2c_ack) begin
            if (idx == IDX_LAST) begin
              state    <= ST_DONE;
              busy     <= 1'b0;
              cfg_done <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_LOAD;
`ifdef CFG_RETRY_EN
              retry_cnt <= '0;
`endif
            end
          end else if (retry_ok) begin
            state <= ST_LOAD;
`ifdef CFG_RETRY_EN
            retry_cnt <= retry_cnt + 1'b1;
`endif
          end else begin
            state     <= ST_ERR;
            busy      <= 1'b0;
            cfg_err   <= 1'b1;
            err_index <= idx;
          end
        end
        // Restart skips power-up: the codec is already powered.
        ST_DONE, ST_ERR: begin
          if (cfg_go) begin
            state    <= ST_LOAD;
            idx      <= '0;
            busy     <= 1'b1;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
`ifdef CFG_RETRY_EN
            retry_cnt <= '0;
`endif
          end
        end
        default: state <= ST_PWRUP;
      endcase
    end
  end

endmodule
